// File: rtl/spi_slave.sv
// SPI slave: oversampled SCLK/SS_N/MOSI, all four CPOL/CPHA modes,
// LSB-first words, single-entry host TX buffer and RX strobe interface.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CPOL_IN,
    input  logic                  CPHA_IN,
    input  logic                  SCLK,
    input  logic                  SS_N,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  MISO_OE,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_LOAD,
    output logic                  TX_EMPTY,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    output logic                  FRAME_ERR,
    output logic                  BUSY
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // synchronizer chains and previous synced values for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, ss_s, mosi_s;

    // frame state
    state_t                 state_q, state_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  tx_buf_q, tx_buf_d;
    logic                   tx_empty_q, tx_empty_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   sampled_q, sampled_d;
    logic                   sample_bit_q, sample_bit_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic                   ss_fall, ss_rise, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge, last_bit;
    logic [DATA_WIDTH-1:0]  shifted;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s    = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];

    assign ss_fall = ss_prev_q & ~ss_s;
    assign ss_rise = ~ss_prev_q & ss_s;

    // leading edge leaves the idle level captured at select, trailing returns to it
    assign lead_edge   = (sclk_prev_q == cpol_q) && (sclk_s != cpol_q);
    assign trail_edge  = (sclk_prev_q != cpol_q) && (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge  : trail_edge;

    assign shifted  = {sample_bit_q, shift_q[DATA_WIDTH-1:1]};
    assign last_bit = (bit_cnt_q == CW'(DATA_WIDTH - 1));

    // bring the asynchronous SPI pins into the CLK domain
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    // frame and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            shift_q      <= '0;
            tx_buf_q     <= '0;
            tx_empty_q   <= 1'b1;
            bit_cnt_q    <= '0;
            sampled_q    <= 1'b0;
            sample_bit_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            shift_q      <= shift_d;
            tx_buf_q     <= tx_buf_d;
            tx_empty_q   <= tx_empty_d;
            bit_cnt_q    <= bit_cnt_d;
            sampled_q    <= sampled_d;
            sample_bit_q <= sample_bit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // next-state: select/deselect handling, sample/shift, word completion, TX buffer
    always_comb begin
        logic completing;
        state_d      = state_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        shift_d      = shift_q;
        tx_buf_d     = tx_buf_q;
        tx_empty_d   = tx_empty_q;
        bit_cnt_d    = bit_cnt_q;
        sampled_d    = sampled_q;
        sample_bit_d = sample_bit_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        completing   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    cpol_d     = CPOL_IN;
                    cpha_d     = CPHA_IN;
                    shift_d    = tx_empty_q ? '0 : tx_buf_q;
                    tx_empty_d = 1'b1;
                    bit_cnt_d  = '0;
                    sampled_d  = 1'b0;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (sample_edge) begin
                    sample_bit_d = mosi_s;
                    sampled_d    = 1'b1;
                end else if (shift_edge && sampled_q) begin
                    sampled_d = 1'b0;
                    if (last_bit) begin
                        // word done: publish it and queue the next TX word if any
                        completing = 1'b1;
                        rx_data_d  = shifted;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        shift_d    = tx_empty_q ? shifted : tx_buf_q;
                        tx_empty_d = 1'b1;
                    end else begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
                if (ss_rise) begin
                    state_d = IDLE;
                    if (!completing) begin
                        frame_err_d = (bit_cnt_q != '0) || sampled_q;
                        bit_cnt_d   = '0;
                        sampled_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // a host load always lands in the buffer after any consumption this cycle
        if (TX_LOAD) begin
            tx_buf_d   = TX_DATA;
            tx_empty_d = 1'b0;
        end
    end

    assign MISO      = shift_q[0];
    assign MISO_OE   = (state_q == ACTIVE);
    assign BUSY      = (state_q == ACTIVE);
    assign TX_EMPTY  = tx_empty_q;
    assign RX_DATA   = rx_data_q;
    assign RX_VALID  = rx_valid_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-word frames plus
// hand-written back-to-back, abort and mid-frame reset sequences.
module tb_spi_slave;

    logic       CLK = 1'b0;
    logic       RST, CPOL_IN, CPHA_IN, SCLK, SS_N, MOSI;
    logic       MISO, MISO_OE, TX_LOAD, TX_EMPTY, RX_VALID, FRAME_ERR, BUSY;
    logic [7:0] TX_DATA, RX_DATA;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_log[$];
    int ferr_cnt = 0;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .CPOL_IN(CPOL_IN), .CPHA_IN(CPHA_IN),
        .SCLK(SCLK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
        .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .TX_EMPTY(TX_EMPTY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // log strobes on the falling edge, away from the register updates
    always @(negedge CLK) begin
        if (!RST) begin
            if (RX_VALID) rx_log.push_back(RX_DATA);
            if (FRAME_ERR) ferr_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    typedef struct {
        logic       cpol;
        logic       cpha;
        int         nload;
        logic [7:0] tx_a;
        logic [7:0] tx_b;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge CLK);
        TX_DATA = d;
        TX_LOAD = 1'b1;
        @(negedge CLK);
        TX_LOAD = 1'b0;
    endtask

    task automatic select(input logic cpol, input logic cpha, input logic mosi0, input logic miso0);
        CPOL_IN = cpol;
        CPHA_IN = cpha;
        SCLK    = cpol;
        clks(4);
        SS_N = 1'b0;
        MOSI = mosi0;
        clks(6);
        chk("miso_lsb_before_edge", MISO, miso0);
        chk("miso_oe_selected", MISO_OE, 1);
        chk("busy_selected", BUSY, 1);
    endtask

    // 8 CLK per SCLK period; the master samples MISO on its own sample edge
    task automatic clock_bits(input logic cpol, input logic cpha, input logic [15:0] mosi,
                              input int nbits, output logic [15:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                MOSI = mosi[i];
                clks(4);
                SCLK = ~cpol;
                miso[i] = MISO;
                clks(4);
                SCLK = cpol;
            end else begin
                SCLK = ~cpol;
                MOSI = mosi[i];
                clks(4);
                SCLK = cpol;
                miso[i] = MISO;
                clks(4);
            end
        end
    endtask

    task automatic deselect(input logic cpol);
        clks(4);
        SS_N = 1'b1;
        clks(4);
        SCLK = cpol;
        clks(4);
    endtask

    // In CPHA=1 the last sampled bit is shifted in by one more leading edge
    // before deselect; without it the frame ends with sampled=1 (an abort).
    task automatic frame(input logic cpol, input logic cpha, input logic [15:0] mosi,
                         input int nbits, input logic miso0, output logic [15:0] miso);
        select(cpol, cpha, mosi[0], miso0);
        clock_bits(cpol, cpha, mosi, nbits, miso);
        if (cpha) begin
            SCLK = ~cpol;
            clks(4);
        end
        deselect(cpol);
    endtask

    initial begin
        vec_t vecs[5];
        logic [15:0] got;
        int n0, f0;
        logic [7:0] rx_hold;
        logic seen;

        vecs[0] = '{cpol:0, cpha:0, nload:1, tx_a:8'hA5, tx_b:8'h00, mosi:8'h55, exp_miso:8'hA5, exp_rx:8'h55};
        vecs[1] = '{cpol:0, cpha:1, nload:1, tx_a:8'h3C, tx_b:8'h00, mosi:8'h33, exp_miso:8'h3C, exp_rx:8'h33};
        vecs[2] = '{cpol:1, cpha:1, nload:1, tx_a:8'h3C, tx_b:8'h00, mosi:8'hAA, exp_miso:8'h3C, exp_rx:8'hAA};
        vecs[3] = '{cpol:0, cpha:0, nload:0, tx_a:8'h00, tx_b:8'h00, mosi:8'hC3, exp_miso:8'h00, exp_rx:8'hC3};
        vecs[4] = '{cpol:1, cpha:0, nload:2, tx_a:8'h11, tx_b:8'h22, mosi:8'h0F, exp_miso:8'h22, exp_rx:8'h0F};

        RST = 1'b1; CPOL_IN = 1'b0; CPHA_IN = 1'b0; SCLK = 1'b0; SS_N = 1'b1;
        MOSI = 1'b0; TX_DATA = '0; TX_LOAD = 1'b0;
        clks(3);
        chk("rst_miso", MISO, 0);
        chk("rst_miso_oe", MISO_OE, 0);
        chk("rst_tx_empty", TX_EMPTY, 1);
        chk("rst_rx_data", RX_DATA, 0);
        chk("rst_rx_valid", RX_VALID, 0);
        chk("rst_frame_err", FRAME_ERR, 0);
        chk("rst_busy", BUSY, 0);
        RST = 1'b0;
        clks(4);

        // single-word frames across modes, underrun and overwrite
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].nload >= 1) load(vecs[v].tx_a);
            if (vecs[v].nload >= 2) load(vecs[v].tx_b);
            chk("tx_empty_before", TX_EMPTY, (vecs[v].nload == 0) ? 1 : 0);
            n0 = rx_log.size();
            f0 = ferr_cnt;
            frame(vecs[v].cpol, vecs[v].cpha, {8'h00, vecs[v].mosi}, 8, vecs[v].exp_miso[0], got);
            chk($sformatf("v%0d_master_rx", v), got[7:0], vecs[v].exp_miso);
            chk($sformatf("v%0d_rx_count", v), rx_log.size() - n0, 1);
            chk($sformatf("v%0d_rx_data", v), RX_DATA, vecs[v].exp_rx);
            chk($sformatf("v%0d_no_frame_err", v), ferr_cnt - f0, 0);
            chk($sformatf("v%0d_tx_empty_after", v), TX_EMPTY, 1);
            chk($sformatf("v%0d_idle_oe", v), MISO_OE, 0);
            chk($sformatf("v%0d_idle_busy", v), BUSY, 0);
        end

        // back-to-back in mode 2; the second word must be buffered before
        // the first word's completing shift, which is where the reload happens
        load(8'h01);
        n0 = rx_log.size();
        f0 = ferr_cnt;
        fork
            frame(1'b1, 1'b0, 16'h126D, 16, 1'b1, got);
            begin
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge CLK);
                    seen = BUSY;
                end
                chk("b2b_busy_timeout", seen, 1);
                clks(2);
                load(8'h02);
            end
        join
        chk("b2b_master_rx", got, 16'h0201);
        chk("b2b_rx_count", rx_log.size() - n0, 2);
        chk("b2b_rx_first", rx_log[n0], 8'h6D);
        chk("b2b_rx_second", RX_DATA, 8'h12);
        chk("b2b_no_frame_err", ferr_cnt - f0, 0);

        // abort after 3 shifts in mode 0
        n0 = rx_log.size();
        f0 = ferr_cnt;
        rx_hold = RX_DATA;
        select(1'b0, 1'b0, 1'b1, 1'b0);
        clock_bits(1'b0, 1'b0, 16'h00FF, 3, got);
        clks(4);
        SS_N = 1'b1;
        clks(3);
        chk("abort_busy", BUSY, 0);
        chk("abort_oe", MISO_OE, 0);
        clks(4);
        chk("abort_frame_err_once", ferr_cnt - f0, 1);
        chk("abort_no_rx_valid", rx_log.size() - n0, 0);
        chk("abort_rx_hold", RX_DATA, rx_hold);

        // reset during bit 4 of a frame
        load(8'h77);
        select(1'b0, 1'b0, 1'b0, 1'b1);
        clock_bits(1'b0, 1'b0, 16'h005A, 4, got);
        load(8'h33);
        chk("pre_rst_tx_empty", TX_EMPTY, 0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        SS_N = 1'b1;
        SCLK = 1'b0;
        chk("mid_rst_miso", MISO, 0);
        chk("mid_rst_oe", MISO_OE, 0);
        chk("mid_rst_tx_empty", TX_EMPTY, 1);
        chk("mid_rst_rx_data", RX_DATA, 0);
        chk("mid_rst_rx_valid", RX_VALID, 0);
        chk("mid_rst_frame_err", FRAME_ERR, 0);
        chk("mid_rst_busy", BUSY, 0);
        clks(6);
        chk("post_rst_still_idle", BUSY, 0);
        n0 = rx_log.size();
        f0 = ferr_cnt;
        load(8'h96);
        frame(1'b0, 1'b0, 16'h005A, 8, 1'b0, got);
        chk("post_rst_master_rx", got[7:0], 8'h96);
        chk("post_rst_rx_count", rx_log.size() - n0, 1);
        chk("post_rst_rx_data", RX_DATA, 8'h5A);
        chk("post_rst_no_frame_err", ferr_cnt - f0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
